// File: rtl/calc_pkg.sv
// Shared calculator definitions: result-bus sentinels, display digit codes and formatter types.
package calc_pkg;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned MAG_W  = 20;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned BCD_W  = DIGITS * 4;
  localparam int unsigned DISP_W = DIGITS * CODE_W;

  localparam logic [31:0]        ANS_NULL = 32'h00CC_0000;
  localparam logic [31:0]        ANS_ERR  = 32'h00EE_0000;
  localparam logic signed [31:0] ANS_MIN  = -32'sd99999;
  localparam logic signed [31:0] ANS_MAX  = 32'sd999999;

  localparam logic [CODE_W-1:0] DIG_BLANK = 5'd16;
  localparam logic [CODE_W-1:0] DIG_MINUS = 5'd17;
  localparam logic [CODE_W-1:0] DIG_E     = 5'd18;
  localparam logic [CODE_W-1:0] DIG_R     = 5'd19;
  localparam logic [CODE_W-1:0] DIG_N     = 5'd20;
  localparam logic [CODE_W-1:0] DIG_U     = 5'd21;
  localparam logic [CODE_W-1:0] DIG_L     = 5'd22;

  // Leftmost digit first in the concatenation
  localparam logic [DISP_W-1:0] PAT_NULL = {DIG_BLANK, DIG_BLANK, DIG_N, DIG_U, DIG_L, DIG_L};
  localparam logic [DISP_W-1:0] PAT_ERR  = {DIG_BLANK, DIG_BLANK, DIG_BLANK, DIG_E, DIG_R, DIG_R};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_CONVERT = 2'd2,
    S_FORMAT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NULL = 2'd0,
    CLS_ERR  = 2'd1,
    CLS_NUM  = 2'd2
  } cls_t;

endpackage

// File: rtl/bin2bcd_serial.sv
// Iterative double-dabble core: load a magnitude, then one add-3/shift step per cycle.
module bin2bcd_serial
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [MAG_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             last_c
);

  logic [MAG_W-1:0] shreg;
  logic [4:0]       cnt;
  logic [BCD_W-1:0] adj_c;

  // Add 3 to every nibble that would overflow past 9 after the shift
  always_comb begin
    adj_c = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign last_c = (cnt == 5'd19);

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd   <= '0;
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      bcd   <= '0;
      shreg <= bin;
      cnt   <= '0;
    end else if (step) begin
      bcd   <= {adj_c[BCD_W-2:0], shreg[MAG_W-1]};
      shreg <= {shreg[MAG_W-2:0], 1'b0};
      cnt   <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/ans_display_fmt.sv
// Converts the calculator ans word into six 7-segment digit codes.
// Define ZERO_BLANK_EN to blank leading zeros and float the minus sign.
module ans_display_fmt
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       ans,
  output logic              busy,
  output logic              done,
  output logic [DISP_W-1:0] digits
);

  state_t            state, state_n;
  logic              busy_n, done_n, load_c, step_c, last_c;
  logic [31:0]       ans_q;
  cls_t              cls_q, cls_c;
  logic              neg_q;
  logic [MAG_W-1:0]  mag_c;
  logic [BCD_W-1:0]  bcd;
  logic [DISP_W-1:0] fmt_c;

  always_comb begin
    cls_c = CLS_ERR;
    mag_c = '0;
    if (ans_q == ANS_NULL) begin
      cls_c = CLS_NULL;
    end else if (ans_q == ANS_ERR) begin
      cls_c = CLS_ERR;
    end else if (($signed(ans_q) >= ANS_MIN) && ($signed(ans_q) <= ANS_MAX)) begin
      cls_c = CLS_NUM;
      mag_c = ans_q[31] ? MAG_W'(-ans_q) : MAG_W'(ans_q);
    end
  end

  bin2bcd_serial u_bcd (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .step   (step_c),
    .bin    (mag_c),
    .bcd    (bcd),
    .last_c (last_c)
  );

  always_comb begin
    state_n = state;
    busy_n  = busy;
    done_n  = 1'b0;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          busy_n  = 1'b1;
        end
      end
      S_LOAD: begin
        load_c  = 1'b1;
        state_n = S_CONVERT;
      end
      S_CONVERT: begin
        step_c = 1'b1;
        if (last_c) state_n = S_FORMAT;
      end
      S_FORMAT: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef ZERO_BLANK_EN
  int msd;
`endif

  // Sign placement and zero handling on the finished BCD value
  always_comb begin
    fmt_c = PAT_ERR;
`ifdef ZERO_BLANK_EN
    msd = 0;
`endif
    case (cls_q)
      CLS_NULL: fmt_c = PAT_NULL;
      CLS_NUM: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          fmt_c[CODE_W*i +: CODE_W] = {1'b0, bcd[4*i +: 4]};
        end
`ifdef ZERO_BLANK_EN
        for (int i = 1; i < int'(DIGITS); i++) begin
          if (bcd[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 1; i < int'(DIGITS); i++) begin
          if (i > msd) fmt_c[CODE_W*i +: CODE_W] = DIG_BLANK;
          if (neg_q && (i == msd + 1)) fmt_c[CODE_W*i +: CODE_W] = DIG_MINUS;
        end
`else
        if (neg_q) fmt_c[CODE_W*(DIGITS-1) +: CODE_W] = DIG_MINUS;
`endif
      end
      default: fmt_c = PAT_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      digits <= PAT_NULL;
      ans_q  <= '0;
      cls_q  <= CLS_NULL;
      neg_q  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
      if ((state == S_IDLE) && start) ans_q <= ans;
      if (load_c) begin
        cls_q <= cls_c;
        neg_q <= (cls_c == CLS_NUM) && ans_q[31];
      end
      if (state == S_FORMAT) digits <= fmt_c;
    end
  end

endmodule

// File: tb/tb_ans_display_fmt.sv
// Directed table-driven bench for ans_display_fmt, plus overlap and reset-abort sequences.
module tb_ans_display_fmt;

`ifdef ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  localparam int B = 16, M = 17, E = 18, R = 19, N = 20, U = 21, L = 22;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [31:0] ans;
  logic [29:0] digits;

  int errors = 0;
  int checks = 0;

  ans_display_fmt dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ans    (ans),
    .busy   (busy),
    .done   (done),
    .digits (digits)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pat(input int d5, input int d4, input int d3,
                                      input int d2, input int d1, input int d0);
    return {5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [29:0] e;
    string       name;
  } vec_t;

  vec_t tv[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one conversion and check latency, busy window and result
  task automatic run(input logic [31:0] a, input logic [29:0] e, input string nm);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1;
    ans   = a;
    @(posedge clk);
    #1;
    start    = 1'b0;
    ans      = 32'hDEAD_BEEF;
    busy_cnt = busy ? 1 : 0;
    cyc      = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = c;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({nm, " latency"}, 32'(cyc), 32'd22);
    check({nm, " busy_cycles"}, 32'(busy_cnt), 32'd22);
    check({nm, " digits"}, 32'(digits), 32'(e));
    check({nm, " busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({nm, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    tv[0]  = '{32'd123, ZB ? pat(B,B,B,1,2,3) : pat(0,0,0,1,2,3), "pos123"};
    tv[1]  = '{-32'sd99999, pat(M,9,9,9,9,9), "neg99999"};
    tv[2]  = '{-32'sd7, ZB ? pat(B,B,B,B,M,7) : pat(M,0,0,0,0,7), "neg7"};
    tv[3]  = '{32'd0, ZB ? pat(B,B,B,B,B,0) : pat(0,0,0,0,0,0), "zero"};
    tv[4]  = '{32'd999999, pat(9,9,9,9,9,9), "max"};
    tv[5]  = '{32'd1000000, pat(B,B,B,E,R,R), "over_max"};
    tv[6]  = '{-32'sd100000, pat(B,B,B,E,R,R), "under_min"};
    tv[7]  = '{32'h00EE_0000, pat(B,B,B,E,R,R), "err_sentinel"};
    tv[8]  = '{32'h00CC_0000, pat(B,B,N,U,L,L), "null_sentinel"};
    tv[9]  = '{32'd42, ZB ? pat(B,B,B,B,4,2) : pat(0,0,0,0,4,2), "pos42"};
    tv[10] = '{-32'sd5, ZB ? pat(B,B,B,B,M,5) : pat(M,0,0,0,0,5), "neg5"};
    tv[11] = '{32'd100000, pat(1,0,0,0,0,0), "pos100000"};
    tv[12] = '{-32'sd1000, ZB ? pat(B,M,1,0,0,0) : pat(M,0,1,0,0,0), "neg1000"};
    tv[13] = '{32'h8000_0000, pat(B,B,B,E,R,R), "most_negative"};

    rst   = 1'b1;
    start = 1'b0;
    ans   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset digits", 32'(digits), 32'(pat(B,B,N,U,L,L)));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run(tv[i].a, tv[i].e, tv[i].name);

    // Second start while busy must be ignored
    begin
      int done_cnt;
      int first_done;
      done_cnt   = 0;
      first_done = 0;
      @(negedge clk);
      start = 1'b1;
      ans   = 32'd123;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
        @(posedge clk);
        #1;
        if (done) begin
          done_cnt++;
          if (first_done == 0) begin
            first_done = c;
            check("overlap digits", 32'(digits), 32'(ZB ? pat(B,B,B,1,2,3) : pat(0,0,0,1,2,3)));
          end
        end
        if (c == 4) begin
          start = 1'b1;
          ans   = 32'd456;
        end else if (c == 5) begin
          start = 1'b0;
        end
      end
      check("overlap latency", 32'(first_done), 32'd22);
      check("overlap done_count", 32'(done_cnt), 32'd1);
      check("overlap idle_busy", 32'(busy), 32'd0);
    end

    // Reset mid-conversion aborts without a done pulse
    begin
      int done_cnt;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      ans   = 32'd555;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        @(posedge clk);
        #1;
        if (done) done_cnt++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort digits", 32'(digits), 32'(pat(B,B,N,U,L,L)));
      for (int c = 1; c <= 30; c++) begin
        @(posedge clk);
        #1;
        if (done) done_cnt++;
      end
      check("abort no_done", 32'(done_cnt), 32'd0);
      run(32'd555, ZB ? pat(B,B,B,5,5,5) : pat(0,0,0,5,5,5), "after_abort");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
